// File: rtl/ripple_seq_ctrl_pkg.sv
// Shared definitions for the ripple counter sequencing controller:
// state encodings and default parameter values.
package ripple_ctrl_defs;

   localparam int D_WIDTH  = 8;
   localparam int D_SETTLE = 2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_PULSE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/ripple_seq_ctrl_settle_timer.sv
// Settle interval down-counter: load at a clear/pulse, expire after SETTLE
// counting cycles. A zero interval reduces to a constant expire.
module settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic expire
);

   generate
      if (SETTLE == 0) begin : g_bypass
         assign expire = 1'b1;
      end else begin : g_cnt
         localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
         localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

         logic [CW-1:0] r_cnt;

         // Terminal count is reached in the last cycle of the interval
         always_ff @(posedge clock) begin
            if (reset) begin
               r_cnt <= '0;
            end else if (load) begin
               r_cnt <= LOAD_VAL;
            end else if (en && (r_cnt != '0)) begin
               r_cnt <= r_cnt - CW'(1);
            end
         end

         assign expire = (r_cnt == '0);
      end
   endgenerate

endmodule

// File: rtl/ripple_seq_ctrl.sv
// Sequences a ripple counter to a requested count, sampling after each
// clear/pulse settle interval and checking against a tracked expected value.
//
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | cnt_clr high for one cycle, settle timer loaded
//   WAIT  | counter settling
//   CHECK | sample cnt_in, compare with expected and target
//   PULSE | t_out high for one cycle, expected incremented
//   DONE  | done pulse, err valid
module ripple_seq_ctrl
   import ripple_ctrl_defs::*;
#(
   parameter int WIDTH  = D_WIDTH,
   parameter int SETTLE = D_SETTLE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_in,
   output logic             t_out,
   output logic             cnt_clr,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] r_expected;
   logic [WIDTH-1:0] r_result;
   logic             r_t_out;
   logic             r_cnt_clr;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_expire;
   logic             w_tmr_load;
   logic             w_tmr_en;
   logic             w_mismatch;
   logic             w_t_out_nxt;
   logic             w_cnt_clr_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_err_nxt;

   assign w_mismatch = (cnt_in != r_expected);
   assign w_tmr_load = (r_state == S_CLEAR) || (r_state == S_PULSE);
   assign w_tmr_en   = (r_state == S_WAIT);

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clock  (clock),
      .reset  (reset),
      .load   (w_tmr_load),
      .en     (w_tmr_en),
      .expire (w_expire)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (abort)             w_state_nxt = S_IDLE;
            else if (SETTLE == 0)  w_state_nxt = S_CHECK;
            else                   w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (abort)             w_state_nxt = S_IDLE;
            else if (w_expire)     w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (abort)                        w_state_nxt = S_IDLE;
            else if (w_mismatch)              w_state_nxt = S_DONE;
            else if (r_expected == r_target)  w_state_nxt = S_DONE;
            else                              w_state_nxt = S_PULSE;
         end
         S_PULSE: begin
            if (abort)             w_state_nxt = S_IDLE;
            else if (SETTLE == 0)  w_state_nxt = S_CHECK;
            else                   w_state_nxt = S_WAIT;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered, so they are decoded from the next state
   always_comb begin
      w_t_out_nxt   = (w_state_nxt == S_PULSE);
      w_cnt_clr_nxt = (w_state_nxt == S_CLEAR);
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_done_nxt    = (w_state_nxt == S_DONE);
      w_err_nxt     = (r_state == S_CHECK) && (w_state_nxt == S_DONE) && w_mismatch;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_t_out   <= 1'b0;
         r_cnt_clr <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_t_out   <= w_t_out_nxt;
         r_cnt_clr <= w_cnt_clr_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_target   <= '0;
         r_expected <= '0;
         r_result   <= '0;
      end else begin
         if ((r_state == S_IDLE) && (w_state_nxt == S_CLEAR)) begin
            r_target   <= target;
            r_expected <= '0;
         end
         if (r_state == S_PULSE) begin
            r_expected <= r_expected + WIDTH'(1);
         end
         // An abort during CHECK leaves the previous sample in place
         if ((r_state == S_CHECK) && !abort) begin
            r_result <= cnt_in;
         end
      end
   end

   assign t_out   = r_t_out;
   assign cnt_clr = r_cnt_clr;
   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign result  = r_result;

endmodule

// File: tb/tb_ripple_seq_ctrl.sv
// Directed bench for ripple_seq_ctrl with a behavioural ripple counter
// model that can drop the increment of the second pulse after a clear.
module tb_ripple_seq_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] target;
   logic       abort;
   logic [7:0] cnt_in;
   logic       t_out;
   logic       cnt_clr;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_cnt = 8'd0;
   int         m_since_clr = 0;
   bit         fault_en = 1'b0;
   int         n_pulse = 0;
   int         n_clr = 0;
   int         n_done = 0;
   int         n_overlap = 0;

   always #5 clock = ~clock;

   ripple_seq_ctrl #(
      .WIDTH  (8),
      .SETTLE (2)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .target  (target),
      .abort   (abort),
      .cnt_in  (cnt_in),
      .t_out   (t_out),
      .cnt_clr (cnt_clr),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   assign cnt_in = m_cnt;

   always @(posedge clock) begin
      if (cnt_clr) begin
         m_cnt       <= 8'd0;
         m_since_clr <= 0;
      end else if (t_out) begin
         m_since_clr <= m_since_clr + 1;
         if (!(fault_en && (m_since_clr == 1))) m_cnt <= m_cnt + 8'd1;
      end
      if (t_out)   n_pulse <= n_pulse + 1;
      if (cnt_clr) n_clr   <= n_clr + 1;
      if (done)    n_done  <= n_done + 1;
   end

   always @(negedge clock) begin
      if (t_out && cnt_clr) n_overlap <= n_overlap + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Starts an operation and waits for done; optionally re-asserts start
   // with a different target in cycle inj while the run is busy.
   task automatic run_op(input logic [7:0] tgt, input bit flt, input int inj,
                         output int cyc, output int e, output int res,
                         output int np, output int nc, output int bsy);
      int np0;
      int nc0;
      fault_en = flt;
      np0 = n_pulse;
      nc0 = n_clr;
      start  = 1'b1;
      target = tgt;
      @(posedge clock); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && (cyc < 1200)) begin
         if (cyc == inj) begin
            start  = 1'b1;
            target = 8'h07;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         cyc++;
      end
      start = 1'b0;
      if (!done) begin
         $display("FAIL run_timeout: target %0d, no done within %0d cycles", tgt, cyc);
         n_cmp++;
         n_bad++;
      end
      e   = int'(err);
      res = int'(result);
      np  = n_pulse - np0;
      nc  = n_clr - nc0;
      bsy = int'(busy);
   endtask

   typedef struct {
      logic [7:0] tgt;
      bit         flt;
      int         inj;
      int         cyc;
      int         e;
      int         res;
      int         np;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int cyc, e, res, np, nc, bsy;
      int snap;
      bit seen;

      vecs[0] = '{tgt: 8'd3,   flt: 1'b0, inj: 0, cyc: 17,   e: 0, res: 3,   np: 3};
      vecs[1] = '{tgt: 8'd0,   flt: 1'b0, inj: 0, cyc: 5,    e: 0, res: 0,   np: 0};
      vecs[2] = '{tgt: 8'd1,   flt: 1'b0, inj: 0, cyc: 9,    e: 0, res: 1,   np: 1};
      vecs[3] = '{tgt: 8'd255, flt: 1'b0, inj: 0, cyc: 1025, e: 0, res: 255, np: 255};
      vecs[4] = '{tgt: 8'd5,   flt: 1'b1, inj: 0, cyc: 13,   e: 1, res: 1,   np: 2};
      vecs[5] = '{tgt: 8'd2,   flt: 1'b0, inj: 3, cyc: 13,   e: 0, res: 2,   np: 2};
      vecs[6] = '{tgt: 8'd10,  flt: 1'b0, inj: 0, cyc: 45,   e: 0, res: 10,  np: 10};

      reset  = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      target = 8'd0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_t_out",   int'(t_out),   0);
      chk("reset_cnt_clr", int'(cnt_clr), 0);
      chk("reset_busy",    int'(busy),    0);
      chk("reset_done",    int'(done),    0);
      chk("reset_err",     int'(err),     0);
      chk("reset_result",  int'(result),  0);
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].tgt, vecs[i].flt, vecs[i].inj, cyc, e, res, np, nc, bsy);
         chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].cyc);
         chk($sformatf("v%0d_err", i),        e,   vecs[i].e);
         chk($sformatf("v%0d_result", i),     res, vecs[i].res);
         chk($sformatf("v%0d_pulses", i),     np,  vecs[i].np);
         chk($sformatf("v%0d_clears", i),     nc,  1);
         chk($sformatf("v%0d_busy_at_done", i), bsy, 1);
         snap = n_pulse;
         @(posedge clock); #1;
         chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
         chk($sformatf("v%0d_done_after", i), int'(done), 0);
         repeat (3) @(posedge clock);
         #1;
         chk($sformatf("v%0d_idle_busy", i),   int'(busy), 0);
         chk($sformatf("v%0d_no_more_pulses", i), n_pulse - snap, 0);
      end
      fault_en = 1'b0;

      // Abort in cycle 6 of a target=4 run (WAIT after the first pulse)
      snap   = n_done;
      start  = 1'b1;
      target = 8'd4;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      chk("abort_busy",    int'(busy),    0);
      chk("abort_t_out",   int'(t_out),   0);
      chk("abort_cnt_clr", int'(cnt_clr), 0);
      chk("abort_counter", int'(m_cnt),   1);
      chk("abort_result",  int'(result),  0);
      repeat (4) @(posedge clock);
      #1;
      chk("abort_no_done", n_done - snap, 0);
      chk("abort_stays_idle", int'(busy), 0);

      // start and abort together in IDLE
      snap   = n_clr;
      start  = 1'b1;
      abort  = 1'b1;
      target = 8'd9;
      @(posedge clock); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", int'(busy), 0);
      repeat (3) @(posedge clock);
      #1;
      chk("start_abort_no_clear", n_clr - snap, 0);
      chk("start_abort_idle",     int'(busy),   0);

      // Reset held for three cycles while t_out is high
      snap   = n_done;
      start  = 1'b1;
      target = 8'd4;
      @(posedge clock); #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (t_out) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      chk("rst_mid_t_out_seen", int'(seen), 1);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_mid_t_out",   int'(t_out),   0);
      chk("rst_mid_busy",    int'(busy),    0);
      chk("rst_mid_cnt_clr", int'(cnt_clr), 0);
      chk("rst_mid_done",    int'(done),    0);
      chk("rst_mid_err",     int'(err),     0);
      chk("rst_mid_result",  int'(result),  0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("rst_mid_no_done", n_done - snap, 0);
      chk("rst_mid_idle",    int'(busy),    0);

      chk("t_out_cnt_clr_overlap", n_overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ripple_seq_ctrl.md
Name: ripple_seq_ctrl

Overview:
Controller that sequences the 8-bit ripple counter (ports o, t, clock, reset) to reach a requested count and verifies every step. The counter has no count-valid indication, so after each clear or toggle pulse the controller waits a programmable settle interval before it samples the counter output. It then checks the sampled value against an internally tracked expected value and reports the result, or a fault, to the requester. It sits between a command source (start/target) and one ripple counter instance.

Parameters:
WIDTH, 8, counter width; sets the width of target, cnt_in and result.
SETTLE, 2, idle cycles after each clear or pulse before sampling; 0 is legal.

Ports:
clock  input  1  system clock; all logic rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only in IDLE.
target  input  WIDTH  requested final count; latched when start is accepted.
abort  input  1  cancels an operation in progress.
cnt_in  input  WIDTH  counter output o.
t_out  output  1  toggle enable to counter t; each clock with t_out=1 increments the counter by 1.
cnt_clr  output  1  clear request to the counter.
busy  output  1  high from the cycle after accept until DONE exits.
done  output  1  one-cycle completion pulse.
err  output  1  valid with done; 1 means a counter mismatch.
result  output  WIDTH  last sampled cnt_in; held until the next accept.

Behaviour:
- Reset is synchronous and active-high. On reset: state=IDLE; t_out, cnt_clr, busy, done, err = 0; result=0; expected=0. A reset mid-operation returns to IDLE at the next edge and drops t_out in that same edge.
- States: IDLE, CLEAR, WAIT, CHECK, PULSE, DONE.
- IDLE: start=1 and abort=0 latches target, sets expected=0, next state CLEAR.
- CLEAR: cnt_clr=1 for exactly 1 cycle. Loads the settle timer with SETTLE. Next state WAIT, or CHECK if SETTLE=0.
- WAIT: counts SETTLE cycles, then goes to CHECK.
- CHECK: samples cnt_in into result.
  - If cnt_in != expected: go to DONE with err=1.
  - Else if expected == target: go to DONE with err=0.
  - Else: go to PULSE.
- PULSE: t_out=1 for exactly 1 cycle. expected <= expected+1, wrapping mod 2^WIDTH. Then WAIT, or CHECK if SETTLE=0.
- DONE: done=1 and err are valid for this single cycle. Next state IDLE. busy is 0 in the following cycle.
- t_out and cnt_clr are registered outputs. They are never high at the same time and never high outside PULSE or CLEAR respectively.
- Latency: for start accepted in cycle 0 with target N, done is high in cycle (2+SETTLE)*(N+1)+1. Exactly N t_out pulses are issued.
- target=0: only the clear and check are performed; no pulses.
- target=2^WIDTH-1 is the maximum legal value. expected never wraps during a correct run.
- abort=1 in any state other than IDLE or DONE: next state IDLE, t_out=0, no done pulse, result keeps the last sampled value. abort in DONE is ignored.
- start while busy is ignored and not queued. abort and start in the same IDLE cycle: abort wins and start is dropped.
- Changes to target after accept have no effect.

Decomposition:
- Shared package/include ripple_ctrl_defs: state encodings (3-bit localparams S_IDLE..S_DONE), default WIDTH and SETTLE.
- One sub-module, settle_timer: load, count-down and expire, parameterised by SETTLE. It is bypassed (expire immediately) when SETTLE=0.
- The FSM, expected register and compare live in ripple_seq_ctrl.

Test Plan:
- Reset held 3 cycles mid-run with t_out high -> t_out=0 after one edge; all outputs 0; no done.
- SETTLE=2, target=3, behavioural counter model: start in cycle 0 -> done at cycle 17, err=0, result=3, exactly 3 t_out pulses, 1 cnt_clr pulse.
- target=0 -> done at cycle 5, result=0, zero t_out pulses.
- target=255 -> done at cycle 1025, result=255, 255 pulses.
- Fault injection: the model skips the increment on the 2nd pulse, target=5 -> done with err=1, result=1, and no further pulses.
- Error cases:
  - abort at cycle 6 of a target=4 run -> IDLE next cycle, busy=0, no done, counter left at 1.
  - start asserted while busy -> ignored.
  - start and abort together in IDLE -> ignored.
